// File: rtl/ami_pkg.sv
// Shared constants, state encoding and helpers for the AXI master read-command engine.
package ami_pkg;

    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam int unsigned BOUNDARY_4K = 4096;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

    // Byte-lane shift: log2 of bytes per data beat.
    function automatic int unsigned byte_shift(input int unsigned dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/ami_burst_calc.sv
// Burst sizer: beats for the next INCR burst, bounded by remaining beats, BL and the 4KB page.
module ami_burst_calc
    import ami_pkg::*;
#(
    parameter int unsigned AXI_DW = 128,
    parameter int unsigned AXI_AW = 32,
    parameter int unsigned AXI_LW = 8,
    parameter int unsigned CNTW   = 16,
    parameter int unsigned BL     = 16,
    parameter int unsigned NW     = $clog2(BL) + 1
) (
    input  logic [AXI_AW-1:0] i_next_addr,
    input  logic [CNTW-1:0]   i_ar_rem,
    output logic [NW-1:0]     o_n,
    output logic [AXI_LW-1:0] o_arlen
);

    localparam int unsigned SHIFT = byte_shift(AXI_DW);
    localparam int unsigned MW    = (CNTW > 13) ? CNTW : 13;

    logic [12:0]   w_dist_bytes;
    logic [12:0]   w_dist_beats;
    logic [MW-1:0] w_min;
    logic          w_unused_addr;

    // Minimum of remaining beats, BL and beats left before the next 4KB page.
    always_comb begin
        w_dist_bytes = 13'(BOUNDARY_4K) - {1'b0, i_next_addr[11:0]};
        w_dist_beats = w_dist_bytes >> SHIFT;
        w_min        = MW'(i_ar_rem);
        if (MW'(BL) < w_min) begin
            w_min = MW'(BL);
        end
        if (MW'(w_dist_beats) < w_min) begin
            w_min = MW'(w_dist_beats);
        end
    end

    assign o_n     = NW'(w_min);
    assign o_arlen = AXI_LW'(w_min - MW'(1));

    assign w_unused_addr = ^i_next_addr[AXI_AW-1:12];

endmodule

// File: rtl/ami_rd_dma.sv
// Read-command engine: splits one linear read into AXI INCR bursts and streams the returned beats.
module ami_rd_dma
    import ami_pkg::*;
#(
    parameter int unsigned AXI_DW     = 128,
    parameter int unsigned AXI_AW     = 32,
    parameter int unsigned AXI_IW     = 8,
    parameter int unsigned AXI_LW     = 8,
    parameter int unsigned AXI_SW     = 3,
    parameter int unsigned AXI_BURSTW = 2,
    parameter int unsigned AXI_RRESPW = 2,
    parameter int unsigned BL         = 16,
    parameter int unsigned CNTW       = 16,
    parameter int unsigned RD_ID      = 0
) (
    input  logic                  usr_clk,
    input  logic                  usr_reset,
    input  logic [AXI_AW-1:0]     cmd_addr,
    input  logic [CNTW-1:0]       cmd_beats,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic [AXI_IW-1:0]     usr_arid,
    output logic [AXI_AW-1:0]     usr_araddr,
    output logic [AXI_LW-1:0]     usr_arlen,
    output logic [AXI_SW-1:0]     usr_arsize,
    output logic [AXI_BURSTW-1:0] usr_arburst,
    output logic                  usr_arvalid,
    input  logic                  usr_arready,
    input  logic [AXI_IW-1:0]     usr_rid,
    input  logic [AXI_DW-1:0]     usr_rdata,
    input  logic [AXI_RRESPW-1:0] usr_rresp,
    input  logic                  usr_rlast,
    input  logic                  usr_rvalid,
    output logic                  usr_rready,
    output logic [AXI_DW-1:0]     dout_data,
    output logic                  dout_last,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned SHIFT = byte_shift(AXI_DW);
    localparam int unsigned NW    = $clog2(BL) + 1;

    rd_state_t          r_state;
    rd_state_t          w_state_nxt;
    logic [AXI_AW-1:0]  r_next_addr;
    logic [CNTW-1:0]    r_ar_rem;
    logic [CNTW-1:0]    r_r_rem;
    logic               r_arvalid;
    logic [AXI_AW-1:0]  r_araddr;
    logic [AXI_LW-1:0]  r_arlen;
    logic               r_done;
    logic               r_err;
    logic               r_cmd_ready;

    logic [NW-1:0]      w_n;
    logic [AXI_LW-1:0]  w_arlen;
    logic [CNTW-1:0]    w_ar_rem_nxt;
    logic               w_active;
    logic               w_cmd_fire;
    logic               w_ar_fire;
    logic               w_beat;
    logic               w_last_beat;
    logic               w_unused_in;

    ami_burst_calc #(
        .AXI_DW (AXI_DW),
        .AXI_AW (AXI_AW),
        .AXI_LW (AXI_LW),
        .CNTW   (CNTW),
        .BL     (BL),
        .NW     (NW)
    ) u_burst_calc (
        .i_next_addr (r_next_addr),
        .i_ar_rem    (r_ar_rem),
        .o_n         (w_n),
        .o_arlen     (w_arlen)
    );

    // Handshake and status decodes.
    assign w_active     = (r_state != ST_IDLE);
    assign w_cmd_fire   = cmd_valid & r_cmd_ready;
    assign w_ar_fire    = r_arvalid & usr_arready;
    assign w_beat       = usr_rvalid & usr_rready;
    assign w_last_beat  = w_beat & (r_r_rem == CNTW'(1));
    assign w_ar_rem_nxt = r_ar_rem - CNTW'(w_n);

    // Zero-latency beat pass-through, closed off outside a command.
    assign dout_data  = usr_rdata;
    assign dout_valid = usr_rvalid & w_active;
    assign usr_rready = dout_ready & w_active;
    assign dout_last  = w_active & (r_r_rem == CNTW'(1));

    assign cmd_ready   = r_cmd_ready;
    assign usr_arvalid = r_arvalid;
    assign usr_araddr  = r_araddr;
    assign usr_arlen   = r_arlen;
    assign usr_arid    = AXI_IW'(RD_ID);
    assign usr_arsize  = AXI_SW'(SHIFT);
    assign usr_arburst = AXI_BURSTW'(BURST_INCR);
    assign done        = r_done;
    assign err         = r_err;

    // RID and RLAST carry no information here: beat counting is authoritative.
    assign w_unused_in = ^{usr_rid, usr_rlast};

    // State register.
    always_ff @(posedge usr_clk) begin
        if (usr_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; the final beat returns to IDLE from either active state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_fire) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_last_beat) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_ar_fire && (w_ar_rem_nxt == '0)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_last_beat) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Command latch, AR generation, beat accounting and status flags.
    always_ff @(posedge usr_clk) begin
        if (usr_reset) begin
            r_next_addr <= '0;
            r_ar_rem    <= '0;
            r_r_rem     <= '0;
            r_arvalid   <= 1'b0;
            r_araddr    <= '0;
            r_arlen     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cmd_ready <= 1'b1;
        end else begin
            r_done      <= w_last_beat;
            r_cmd_ready <= (w_state_nxt == ST_IDLE);
            if (w_cmd_fire) begin
                r_next_addr <= cmd_addr;
                r_ar_rem    <= cmd_beats;
                r_r_rem     <= cmd_beats;
                r_err       <= 1'b0;
                r_arvalid   <= 1'b0;
            end else begin
                if (w_beat) begin
                    r_r_rem <= r_r_rem - CNTW'(1);
                    if (usr_rresp != '0) begin
                        r_err <= 1'b1;
                    end
                end
                if (r_state == ST_ISSUE) begin
                    if (w_ar_fire) begin
                        r_arvalid   <= 1'b0;
                        r_next_addr <= r_next_addr + (AXI_AW'(w_n) << SHIFT);
                        r_ar_rem    <= w_ar_rem_nxt;
                    end else if (!r_arvalid && (r_ar_rem != '0)) begin
                        r_arvalid <= 1'b1;
                        r_araddr  <= r_next_addr;
                        r_arlen   <= w_arlen;
                    end
                end
                if (w_last_beat) begin
                    r_arvalid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ami_rd_dma.sv
// Directed bench for ami_rd_dma: burst splitting, 4KB split, backpressure, error and reset.
module tb_ami_rd_dma;

    logic         usr_clk = 1'b0;
    logic         usr_reset;
    logic [31:0]  cmd_addr;
    logic [15:0]  cmd_beats;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [7:0]   usr_arid;
    logic [31:0]  usr_araddr;
    logic [7:0]   usr_arlen;
    logic [2:0]   usr_arsize;
    logic [1:0]   usr_arburst;
    logic         usr_arvalid;
    logic         usr_arready;
    logic [7:0]   usr_rid;
    logic [127:0] usr_rdata;
    logic [1:0]   usr_rresp;
    logic         usr_rlast;
    logic         usr_rvalid;
    logic         usr_rready;
    logic [127:0] dout_data;
    logic         dout_last;
    logic         dout_valid;
    logic         dout_ready;
    logic         done;
    logic         err;

    int  n_checks = 0;
    int  n_errors = 0;
    bit  tog      = 1'b0;

    always #5 usr_clk = ~usr_clk;

    ami_rd_dma dut (
        .usr_clk     (usr_clk),
        .usr_reset   (usr_reset),
        .cmd_addr    (cmd_addr),
        .cmd_beats   (cmd_beats),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .usr_arid    (usr_arid),
        .usr_araddr  (usr_araddr),
        .usr_arlen   (usr_arlen),
        .usr_arsize  (usr_arsize),
        .usr_arburst (usr_arburst),
        .usr_arvalid (usr_arvalid),
        .usr_arready (usr_arready),
        .usr_rid     (usr_rid),
        .usr_rdata   (usr_rdata),
        .usr_rresp   (usr_rresp),
        .usr_rlast   (usr_rlast),
        .usr_rvalid  (usr_rvalid),
        .usr_rready  (usr_rready),
        .dout_data   (dout_data),
        .dout_last   (dout_last),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .done        (done),
        .err         (err)
    );

    task automatic tick();
        @(posedge usr_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [31:0] addr, input logic [15:0] beats);
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        chk("cmd_legal", {127'd0, (beats != 16'd0) && (addr[3:0] == 4'd0)}, 128'd1);
        cmd_addr  = addr;
        cmd_beats = beats;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("cmd_ready_busy", cmd_ready, 1'b0);
        chk("err_cleared", err, 1'b0);
        chk("arvalid_first_cycle", usr_arvalid, 1'b0);
    endtask

    task automatic expect_ar(input logic [31:0] addr, input logic [7:0] len, input int stall);
        int w;
        w = 0;
        while (usr_arvalid !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk("ar_valid", usr_arvalid, 1'b1);
        chk("ar_addr", usr_araddr, addr);
        chk("ar_len", usr_arlen, len);
        chk("ar_size", usr_arsize, 3'd4);
        chk("ar_burst", usr_arburst, 2'b01);
        chk("ar_id", usr_arid, 8'd0);
        for (int s = 0; s < stall; s++) begin
            tick();
            chk("ar_hold_valid", usr_arvalid, 1'b1);
            chk("ar_hold_addr", usr_araddr, addr);
            chk("ar_hold_len", usr_arlen, len);
        end
        usr_arready = 1'b1;
        tick();
        usr_arready = 1'b0;
        chk("ar_drop", usr_arvalid, 1'b0);
    endtask

    task automatic send_beat(input logic [127:0] data, input logic [1:0] resp,
                             input logic exp_last, input bit toggle);
        bit got;
        got        = 1'b0;
        usr_rvalid = 1'b1;
        usr_rdata  = data;
        usr_rresp  = resp;
        for (int k = 0; k < 8 && !got; k++) begin
            dout_ready = toggle ? tog : 1'b1;
            tog        = ~tog;
            #1;
            chk("dout_valid", dout_valid, 1'b1);
            chk("dout_data", dout_data, data);
            chk("dout_last", dout_last, exp_last);
            chk("rready_follow", usr_rready, dout_ready);
            got = dout_ready;
            tick();
        end
        usr_rvalid = 1'b0;
        dout_ready = 1'b1;
        chk("beat_accepted", got, 1'b1);
    endtask

    task automatic end_cmd(input logic exp_err);
        chk("done_pulse", done, 1'b1);
        chk("cmd_ready_after", cmd_ready, 1'b1);
        chk("err_at_done", err, exp_err);
        tick();
        chk("done_clear", done, 1'b0);
        chk("err_hold", err, exp_err);
    endtask

    initial begin
        usr_reset   = 1'b1;
        cmd_addr    = '0;
        cmd_beats   = '0;
        cmd_valid   = 1'b0;
        usr_arready = 1'b0;
        usr_rid     = '0;
        usr_rdata   = '0;
        usr_rresp   = '0;
        usr_rlast   = 1'b0;
        usr_rvalid  = 1'b0;
        dout_ready  = 1'b1;
        repeat (3) tick();
        usr_reset = 1'b0;
        tick();

        // Reset state
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_arvalid", usr_arvalid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("idle_rready", usr_rready, 1'b0);
        chk("idle_dout_valid", dout_valid, 1'b0);

        // 1: 40 beats at 0x1000 -> 16 + 16 + 8, first burst's beats during ISSUE
        send_cmd(32'h0000_1000, 16'd40);
        expect_ar(32'h0000_1000, 8'd15, 0);
        for (int i = 0; i < 16; i++) send_beat(128'hA000 + 128'(i), 2'b00, 1'b0, 1'b0);
        chk("t1_no_early_done", done, 1'b0);
        expect_ar(32'h0000_1100, 8'd15, 0);
        expect_ar(32'h0000_1200, 8'd7, 0);
        for (int i = 16; i < 40; i++) send_beat(128'hA000 + 128'(i), 2'b00, 1'(i == 39), 1'b0);
        end_cmd(1'b0);

        // 2: 10 beats at 0x1FC0 -> 4KB split into 4 + 6, misleading RLAST ignored
        usr_rlast = 1'b1;
        send_cmd(32'h0000_1FC0, 16'd10);
        expect_ar(32'h0000_1FC0, 8'd3, 0);
        expect_ar(32'h0000_2000, 8'd5, 0);
        for (int i = 0; i < 10; i++) send_beat(128'hB000 + 128'(i), 2'b00, 1'(i == 9), 1'b0);
        end_cmd(1'b0);
        usr_rlast = 1'b0;

        // 3: single beat at 0x0
        send_cmd(32'h0000_0000, 16'd1);
        expect_ar(32'h0000_0000, 8'd0, 0);
        send_beat(128'hC0FFEE, 2'b00, 1'b1, 1'b0);
        end_cmd(1'b0);

        // 4: AR stalls of 5 cycles and toggling consumer ready
        send_cmd(32'h0000_3000, 16'd20);
        expect_ar(32'h0000_3000, 8'd15, 5);
        for (int i = 0; i < 16; i++) send_beat(128'hD000 + 128'(i), 2'b00, 1'b0, 1'b1);
        expect_ar(32'h0000_3100, 8'd3, 5);
        for (int i = 16; i < 20; i++) send_beat(128'hD000 + 128'(i), 2'b00, 1'(i == 19), 1'b1);
        end_cmd(1'b0);

        // 5: SLVERR on beat 7 of 16 sets sticky err
        send_cmd(32'h0000_4000, 16'd16);
        expect_ar(32'h0000_4000, 8'd15, 0);
        for (int i = 0; i < 16; i++) begin
            send_beat(128'hE000 + 128'(i), (i == 6) ? 2'b10 : 2'b00, 1'(i == 15), 1'b0);
            chk("t5_err_track", err, 1'(i >= 6));
        end
        end_cmd(1'b1);

        // 6: reset mid-ISSUE with err set and an AR pending, then a fresh command
        send_cmd(32'h0000_5000, 16'd32);
        expect_ar(32'h0000_5000, 8'd15, 0);
        send_beat(128'hF000, 2'b11, 1'b0, 1'b0);
        chk("t6_err_set", err, 1'b1);
        chk("t6_ar2_pending", usr_arvalid, 1'b1);
        usr_reset = 1'b1;
        tick();
        usr_reset = 1'b0;
        chk("t6_rst_cmd_ready", cmd_ready, 1'b1);
        chk("t6_rst_arvalid", usr_arvalid, 1'b0);
        chk("t6_rst_done", done, 1'b0);
        chk("t6_rst_err", err, 1'b0);
        chk("t6_rst_rready", usr_rready, 1'b0);
        send_cmd(32'h0000_6000, 16'd2);
        expect_ar(32'h0000_6000, 8'd1, 0);
        send_beat(128'h6000, 2'b00, 1'b0, 1'b0);
        send_beat(128'h6001, 2'b00, 1'b1, 1'b0);
        end_cmd(1'b0);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ami_rd_dma.md
Name: ami_rd_dma

Overview:
- Single-clock read-command engine on the user side of the AXI master read interface.
- Accepts one linear read command (aligned start address plus beat count) and splits it into INCR bursts of at most BL beats, never crossing a 4KB boundary.
- Issues the bursts on the usr_ar* channel and streams the returned usr_r* beats to a consumer, marking the final beat of the command.
- Reports completion and a sticky error.

Parameters:
- AXI_DW, 128, data bus width
- AXI_AW, 32, address width
- AXI_IW, 8, ID width
- AXI_LW, 8, ARLEN width
- AXI_SW, 3, ARSIZE width
- AXI_BURSTW, 2, ARBURST width
- AXI_RRESPW, 2, RRESP width
- BL, 16, maximum beats per burst (power of 2, ≤256)
- CNTW, 16, command beat-count width
- RD_ID, 0, constant ARID driven on every burst

Ports:
- usr_clk  in  1  clock
- usr_reset  in  1  synchronous active-high reset
- cmd_addr  in  AXI_AW  start byte address; must be AXI_DW/8-aligned
- cmd_beats  in  CNTW  beats to read; 0 is illegal
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid&ready
- usr_arid/araddr/arlen/arsize/arburst  out  AXI_IW/AXI_AW/AXI_LW/AXI_SW/AXI_BURSTW  burst request
- usr_arvalid  out  1  request valid
- usr_arready  in  1  request ready
- usr_rid/rdata/rresp/rlast  in  AXI_IW/AXI_DW/AXI_RRESPW/1  read beat
- usr_rvalid  in  1  beat valid
- usr_rready  out  1  beat ready
- dout_data  out  AXI_DW  data to consumer
- dout_last  out  1  last beat of whole command
- dout_valid  out  1  data valid
- dout_ready  in  1  consumer ready
- done  out  1  one-cycle pulse when command fully received
- err  out  1  sticky: any beat of current command had rresp≠0

Behaviour:
- Reset (synchronous, usr_reset=1 at posedge): FSM=IDLE; cmd_ready=1; usr_arvalid=0; done=0; err=0; all counters 0. Reset mid-command abandons the command without draining.
- FSM IDLE: cmd_ready=1. On cmd_valid&cmd_ready:
  - latch next_addr=cmd_addr, ar_rem=cmd_beats, r_rem=cmd_beats
  - clear err; go to ISSUE
- FSM ISSUE: cmd_ready=0.
  - Burst beats N = min(ar_rem, BL, (4096-next_addr[11:0])>>log2(AXI_DW/8)).
  - usr_arvalid is registered: it asserts the cycle after entering ISSUE or after the previous AR handshake, with araddr=next_addr, arlen=N-1, arsize=log2(AXI_DW/8), arburst=2'b01, arid=RD_ID.
  - Outputs hold stable while arvalid=1 and arready=0.
  - On handshake: next_addr += N*AXI_DW/8; ar_rem -= N.
  - When ar_rem reaches 0, go to DRAIN.
- FSM DRAIN: no AR issued; wait until r_rem=0.
- Data path:
  - dout_data=usr_rdata, dout_valid=usr_rvalid, usr_rready=dout_ready (combinational pass-through, zero latency).
  - Beats are passed in both ISSUE and DRAIN.
  - Each beat handshake decrements r_rem.
  - dout_last=1 when r_rem==1.
  - err |= (usr_rresp≠0) on each beat handshake.
- Completion: the beat handshake that takes r_rem 1→0 sets done=1 for the next cycle only and returns the FSM to IDLE. cmd_ready=1 that same cycle, so back-to-back commands are permitted.
- usr_rlast is not used for counting; beat-count accounting is authoritative. A usr_rlast that disagrees with the expected burst boundary is ignored.
- Outside a command (IDLE), usr_rready=0.
- Widths:
  - next_addr wraps modulo 2^AXI_AW.
  - Counters are CNTW bits; 4KB distance is computed in 13 bits.
  - N fits in $clog2(BL)+1 bits.
- Illegal inputs (unaligned address, cmd_beats=0) are undefined; the verification bench flags them with an assertion.

Decomposition:
- Package ami_pkg holds:
  - burst encoding constants (BURST_INCR=2'b01)
  - the 4KB boundary constant (4096)
  - the derived byte-shift function log2(AXI_DW/8)
- One natural sub-module: ami_burst_calc, combinational. Inputs next_addr, ar_rem, BL; outputs N and arlen. It is unit-testable on its own.
- FSM, counters and data path stay in the top module.

Test Plan (AXI_DW=128, so 16B/beat, 256 beats per 4KB; BL=16):
1. cmd_addr=0x1000, cmd_beats=40, arready=1 → three ARs:
   - 0x1000 len 15
   - 0x1100 len 15
   - 0x1200 len 7
   - → 40 beats out, dout_last on the 40th, done pulse one cycle later, err=0.
2. cmd_addr=0x1FC0, cmd_beats=10 → ARs 0x1FC0 len 3 (4KB split) and 0x2000 len 5; ten beats delivered.
3. cmd_beats=1 at 0x0 → AR len 0; the single beat has dout_last=1; done follows.
4. Backpressure: arready low for 5 cycles and dout_ready toggled every cycle → AR fields stay stable while stalled; no beats lost or duplicated; beat order preserved.
5. Beat 7 of a 16-beat command returns rresp=2'b10 → err=1 after that beat and held through done; err cleared by the next command acceptance.
6. usr_reset asserted mid-ISSUE → next cycle cmd_ready=1, usr_arvalid=0, done=0, err=0; a new command then runs correctly.
